wb_rob: RTL and testbench

WB_ROB -- requirements
Module: wb_rob

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_rob.sv | 154 +++++++++++++++
 tb/tb_wb_rob.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the in-order writeback reorder buffer.
package wb_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int DW_DEF    = 32;

    // One writeback slot. The data field uses the package data width, so a
    // wb_rob instance is expected to run with DW equal to DW_DEF.
    typedef struct packed {
        logic              valid;
        logic              ready;
        logic [3:0]        dst;
        logic [DW_DEF-1:0] data;
    } slot_t;

endpackage

// File: rtl/wb_rob.sv
// In-order writeback reorder buffer: ALU results and issued loads take
// slots in program order, loads are filled as their data returns in issue
// order, and the oldest ready slot drives one register-file write per cycle.
module wb_rob
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [3:0]    alu_dst,
    input  logic [DW-1:0] alu_data,
    input  logic          ld_issue,
    input  logic [3:0]    ld_dst,
    input  logic          ld_ret_valid,
    input  logic [DW-1:0] ld_ret_data,
    output logic          stall,
    output logic          wr,
    output logic [3:0]    wr_dst,
    output logic [DW-1:0] wr_data,
    output logic          err
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    slot_t          slots_r [DEPTH];
    logic [AW-1:0]  head_r;
    logic [AW-1:0]  tail_r;
    logic [AW:0]    count_r;
    logic           wr_r;
    logic [3:0]     wr_dst_r;
    logic [DW-1:0]  wr_data_r;
    logic           err_r;

    logic           full_s;
    logic           push_req_s;
    logic           push_s;
    logic           pop_s;
    logic           pending_s;
    logic [AW-1:0]  fill_s;
    logic [AW-1:0]  idx_s;
    logic           fill_go_s;
    logic           err_evt_s;
    slot_t          new_slot_s;

    assign full_s     = (count_r == FULL_CNT);
    assign stall      = full_s;
    assign push_req_s = alu_valid | ld_issue;
    // A full buffer drops the enqueue even when the head pops this cycle.
    assign push_s     = push_req_s & ~full_s;
    // A slot filled this cycle still reads ready=0, so it pops next cycle at the earliest.
    assign pop_s      = slots_r[head_r].valid & slots_r[head_r].ready;
    assign fill_go_s  = ld_ret_valid & pending_s;
    assign err_evt_s  = (alu_valid & ld_issue)
                      | (push_req_s & full_s)
                      | (ld_ret_valid & ~pending_s);

    assign wr      = wr_r;
    assign wr_dst  = wr_dst_r;
    assign wr_data = wr_data_r;
    assign err     = err_r;

    // Fill pointer: oldest valid slot still waiting for load data, scanned from head.
    always_comb begin
        fill_s    = '0;
        idx_s     = '0;
        pending_s = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            idx_s = head_r + AW'(i);
            if (slots_r[idx_s].valid && !slots_r[idx_s].ready) begin
                fill_s    = idx_s;
                pending_s = 1'b1;
            end else begin
                pending_s = pending_s;
            end
        end
    end

    // Build the entry to enqueue; a load wins over a simultaneous ALU result.
    always_comb begin
        new_slot_s       = '0;
        new_slot_s.valid = 1'b1;
        if (ld_issue) begin
            new_slot_s.ready = 1'b0;
            new_slot_s.dst   = ld_dst;
            new_slot_s.data  = '0;
        end else begin
            new_slot_s.ready = 1'b1;
            new_slot_s.dst   = alu_dst;
            new_slot_s.data  = alu_data;
        end
    end

    // Slot storage and head/tail/count bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_r[i] <= '0;
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (pop_s) begin
                slots_r[head_r].valid <= 1'b0;
                slots_r[head_r].ready <= 1'b0;
                head_r                <= head_r + AW'(1);
            end
            if (fill_go_s) begin
                slots_r[fill_s].ready <= 1'b1;
                slots_r[fill_s].data  <= ld_ret_data;
            end
            if (push_s) begin
                slots_r[tail_r] <= new_slot_s;
                tail_r          <= tail_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Register-file write port, registered from the popped head slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_r      <= 1'b0;
            wr_dst_r  <= 4'd0;
            wr_data_r <= '0;
        end else if (pop_s) begin
            wr_r      <= 1'b1;
            wr_dst_r  <= slots_r[head_r].dst;
            wr_data_r <= slots_r[head_r].data;
        end else begin
            wr_r      <= 1'b0;
        end
    end

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (err_evt_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

endmodule

// File: tb/tb_wb_rob.sv
// Self-checking bench for wb_rob: a queue-based program-order model predicts
// every write, the stall level and the sticky error flag each cycle.
module tb_wb_rob;

    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic          clk;
    logic          rst;
    logic          alu_valid;
    logic [3:0]    alu_dst;
    logic [DW-1:0] alu_data;
    logic          ld_issue;
    logic [3:0]    ld_dst;
    logic          ld_ret_valid;
    logic [DW-1:0] ld_ret_data;
    logic          stall;
    logic          wr;
    logic [3:0]    wr_dst;
    logic [DW-1:0] wr_data;
    logic          err;

    wb_rob #(.DEPTH(DEPTH), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_dst      (alu_dst),
        .alu_data     (alu_data),
        .ld_issue     (ld_issue),
        .ld_dst       (ld_dst),
        .ld_ret_valid (ld_ret_valid),
        .ld_ret_data  (ld_ret_data),
        .stall        (stall),
        .wr           (wr),
        .wr_dst       (wr_dst),
        .wr_data      (wr_data),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: program-order list of outstanding instructions.
    typedef struct {
        logic [3:0]  dst;
        logic [31:0] data;
        bit          ready;
    } ent_t;

    ent_t        q[$];
    logic        m_wr;
    logic [3:0]  m_dst;
    logic [31:0] m_data;
    logic        m_err;

    int n_checks;
    int n_errors;
    int wr_pulses;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("stall", {63'd0, stall}, {63'd0, (q.size() == DEPTH)});
        check_eq("wr", {63'd0, wr}, {63'd0, m_wr});
        check_eq("wr_dst", {60'd0, wr_dst}, {60'd0, m_dst});
        check_eq("wr_data", {32'd0, wr_data}, {32'd0, m_data});
        check_eq("err", {63'd0, err}, {63'd0, m_err});
        if (wr === 1'b1) wr_pulses++;
    endtask

    // One cycle: check current outputs, then drive inputs and advance the model.
    task automatic step(input logic r, input logic av, input logic [3:0] ad, input logic [31:0] adat,
                        input logic li, input logic [3:0] ldd, input logic rv, input logic [31:0] rd);
        int  fi;
        bit  pop;
        bit  full;
        ent_t e;
        @(negedge clk);
        check_outputs();
        rst = r; alu_valid = av; alu_dst = ad; alu_data = adat;
        ld_issue = li; ld_dst = ldd; ld_ret_valid = rv; ld_ret_data = rd;
        if (r) begin
            q.delete();
            m_err = 1'b0; m_wr = 1'b0; m_dst = 4'd0; m_data = 32'd0;
        end else begin
            pop  = (q.size() > 0) && q[0].ready;
            full = (q.size() == DEPTH);
            fi   = -1;
            for (int i = 0; i < q.size(); i++) begin
                if (fi < 0 && !q[i].ready) fi = i;
            end
            if (rv) begin
                if (fi >= 0) begin
                    q[fi].ready = 1'b1;
                    q[fi].data  = rd;
                end else begin
                    m_err = 1'b1;
                end
            end
            m_wr = pop;
            if (pop) begin
                m_dst  = q[0].dst;
                m_data = q[0].data;
            end
            if (av && li) m_err = 1'b1;
            if (av || li) begin
                if (full) begin
                    m_err = 1'b1;
                end else begin
                    e.dst   = li ? ldd : ad;
                    e.data  = li ? 32'd0 : adat;
                    e.ready = !li;
                    if (pop) void'(q.pop_front());
                    q.push_back(e);
                    pop = 1'b0;
                end
            end
            if (pop) void'(q.pop_front());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0);
    endtask

    int  pulses_before;
    bit  av, li, rv;
    bit  pend;

    initial begin
        n_checks = 0; n_errors = 0; wr_pulses = 0;
        rst = 1'b1; alu_valid = 1'b0; alu_dst = 4'd0; alu_data = 32'd0;
        ld_issue = 1'b0; ld_dst = 4'd0; ld_ret_valid = 1'b0; ld_ret_data = 32'd0;
        m_wr = 1'b0; m_dst = 4'd0; m_data = 32'd0; m_err = 1'b0;

        do_reset();

        // ALU r3 = 0xAA: single write two cycles later.
        step(1'b0, 1'b1, 4'd3, 32'h0000_00AA, 1'b0, 4'd0, 1'b0, 32'd0);
        idle(4);

        // Load r5 blocks younger ALU r6 until data returns.
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 1'b0, 32'd0);
        step(1'b0, 1'b1, 4'd6, 32'h0000_0011, 1'b0, 4'd0, 1'b0, 32'd0);
        idle(2);
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 32'hDEAD_BEEF);
        idle(4);

        // Four loads fill the buffer, fifth enqueue is dropped, returns drain in order.
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'(i), 1'b0, 32'd0);
        step(1'b0, 1'b1, 4'd9, 32'h0000_0099, 1'b0, 4'd0, 1'b0, 32'd0);
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 32'h1000_0000 + 32'(i));
        idle(4);

        // ALU and load in the same cycle: only the load is kept.
        do_reset();
        step(1'b0, 1'b1, 4'd7, 32'h0000_0077, 1'b1, 4'd8, 1'b0, 32'd0);
        idle(2);
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 32'h0000_0088);
        idle(3);

        // Load return with nothing pending.
        do_reset();
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 32'h0BAD_0BAD);
        idle(3);

        // Reset with three slots queued discards them without a write.
        do_reset();
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 1'b0, 32'd0);
        step(1'b0, 1'b1, 4'd3, 32'h0000_0033, 1'b0, 4'd0, 1'b0, 32'd0);
        pulses_before = wr_pulses;
        step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0);
        idle(4);
        check_eq("no_wr_after_reset", 64'(wr_pulses), 64'(pulses_before));

        // Randomized traffic, mostly legal, with rare violations and resets.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            pend = 1'b0;
            foreach (q[i]) if (!q[i].ready) pend = 1'b1;
            av = ($urandom_range(0, 2) == 0);
            li = ($urandom_range(0, 3) == 0);
            rv = pend && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) != 0) begin
                if (av && li) av = 1'b0;
                if (q.size() == DEPTH) begin
                    av = 1'b0;
                    li = 1'b0;
                end
            end
            if ($urandom_range(0, 199) == 0) rv = 1'b1;
            step(($urandom_range(0, 299) == 0), av, 4'($urandom), $urandom,
                 li, 4'($urandom), rv, $urandom);
        end
        idle(6);

        @(negedge clk);
        check_outputs();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
